// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if : instruction/flag inputs and datapath controls of the
//                      multicycle controller.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface multicycle_ctrl_if;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite;
    logic         IRWrite;
    logic         RegWrite;
    logic         MemWrite;
    logic         AdrSrc;
    logic [1:0]   RegSrc;
    logic [1:0]   ImmSrc;
    logic         ALUSrcA;
    logic [1:0]   ALUSrcB;
    logic [1:0]   ResultSrc;
    logic [1:0]   ALUControl;
    logic [3:0]   State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, State
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl : ARM-subset multicycle control FSM with conditional flags.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl (
    input  logic              clk,
    input  logic              reset1,
    multicycle_ctrl_if.master bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;

    logic [3:0] state_q, state_d;
    logic [3:0] flags_q, flags_d;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic       w_rd_pc;
    logic       w_unused;
    logic       w_n, w_z, w_c, w_v;
    logic       w_cond_ex;
    logic [1:0] w_alu_ctl;
    logic       w_alu_ok;
    logic       w_alu_arith;
    logic       w_pc_we, w_ir_we, w_reg_we, w_mem_we;

    assign w_cond   = bus.Instr[31:28];
    assign w_op     = bus.Instr[27:26];
    assign w_funct  = bus.Instr[25:20];
    assign w_rd_pc  = (bus.Instr[15:12] == 4'hF);
    assign w_unused = ^bus.Instr[19:16];
    assign {w_n, w_z, w_c, w_v} = flags_q;

    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Unsupported opcodes run as a harmless ADD with no architectural effect.
    always_comb begin
        w_alu_ctl   = 2'b00;
        w_alu_ok    = 1'b1;
        w_alu_arith = 1'b0;
        case (w_funct[4:1])
            4'b0100: w_alu_arith = 1'b1;
            4'b0010: begin w_alu_ctl = 2'b01; w_alu_arith = 1'b1; end
            4'b0000: w_alu_ctl = 2'b10;
            4'b1100: w_alu_ctl = 2'b11;
            default: w_alu_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset1) begin
        if (!reset1) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECUTER || state_q == S_EXECUTEI) &&
            w_funct[0] && w_cond_ex && w_alu_ok) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
            if (w_alu_arith) flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!w_cond_ex)          state_d = S_FETCH;
                else case (w_op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = w_funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_we        = 1'b0;
        w_ir_we        = 1'b0;
        w_reg_we       = 1'b0;
        w_mem_we       = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ALUControl = 2'b00;
        case (state_q)
            S_FETCH: begin
                w_pc_we = 1'b1; w_ir_we = 1'b1;
                bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
            end
            S_DECODE: begin
                bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
            end
            S_MEMADR:   bus.ALUSrcB = 2'b01;
            S_MEMRD:    bus.AdrSrc  = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01; w_reg_we = 1'b1; w_pc_we = w_rd_pc;
            end
            S_MEMWR: begin
                bus.AdrSrc = 1'b1; w_mem_we = 1'b1;
            end
            S_EXECUTER: bus.ALUControl = w_alu_ctl;
            S_EXECUTEI: begin
                bus.ALUSrcB = 2'b01; bus.ALUControl = w_alu_ctl;
            end
            S_ALUWB: begin
                w_reg_we = w_alu_ok; w_pc_we = w_rd_pc & w_alu_ok;
            end
            S_BRANCH: begin
                bus.ALUSrcB = 2'b01; bus.ResultSrc = 2'b10; w_pc_we = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated directly by reset so they drop without waiting for clk.
    assign bus.PCWrite  = w_pc_we  & reset1;
    assign bus.IRWrite  = w_ir_we  & reset1;
    assign bus.RegWrite = w_reg_we & reset1;
    assign bus.MemWrite = w_mem_we & reset1;
    assign bus.ImmSrc   = w_op;
    assign bus.RegSrc   = {w_op == 2'b01, w_op == 2'b10};
    assign bus.State    = state_q;
endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl : directed scoreboard bench for multicycle_ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;
    logic clk;
    logic reset1;
    int   checks = 0;
    int   errors = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk    (clk),
        .reset1 (reset1),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic [3:0] we;
        logic [1:0] ctl;
        logic [3:0] src;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {care mask, value} for {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
    function automatic logic [15:0] ctl_ref(input logic [3:0] st, input logic [1:0] c);
        case (st)
            4'd0:    return {8'hFF, 8'b0_1_10_10_00};
            4'd1:    return {8'h7F, 8'b0_1_10_10_00};
            4'd2:    return {8'h73, 8'b0_0_01_00_00};
            4'd3:    return {8'h8C, 8'b1_0_00_00_00};
            4'd4:    return {8'h0C, 8'b0_0_00_01_00};
            4'd5:    return {8'h80, 8'b1_0_00_00_00};
            4'd6:    return {8'h73, {6'b0_0_00_00, c}};
            4'd7:    return {8'h73, {6'b0_0_01_00, c}};
            4'd8:    return {8'h0C, 8'b0_0_00_00_00};
            4'd9:    return {8'h7F, 8'b0_0_01_10_00};
            default: return {8'h00, 8'h00};
        endcase
    endfunction

    function automatic logic [7:0] obs_cv();
        return {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl};
    endfunction

    function automatic logic [7:0] obs_we();
        return {4'h0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite};
    endfunction

    task automatic check_cycle(input exp_t e, input logic [19:0] instr);
        logic [15:0] r;
        r = ctl_ref(e.state, e.ctl);
        chk($sformatf("state@%h", instr), {4'h0, bus.State}, {4'h0, e.state});
        chk($sformatf("we@%h/s%0d", instr, e.state), obs_we(), {4'h0, e.we});
        chk($sformatf("ctl@%h/s%0d", instr, e.state), obs_cv() & r[15:8], r[7:0] & r[15:8]);
        chk($sformatf("src@%h", instr), {4'h0, bus.RegSrc, bus.ImmSrc}, {4'h0, e.src});
    endtask

    // Enter at posedge+1 of a FETCH cycle; leaves at posedge+1 of the next one
    // unless hold is set, in which case it stops at the last compared negedge.
    task automatic issue(input logic [19:0] instr, input logic [3:0] fl, input int n,
                         input logic [19:0] sts, input logic [19:0] wes,
                         input logic [1:0] ctl, input bit hold);
        exp_t e;
        logic [1:0] op;
        op = instr[15:14];
        bus.Instr    = instr;
        bus.ALUFlags = fl;
        for (int k = 0; k < n; k++) begin
            e.state = sts[4*(n-1-k) +: 4];
            e.we    = wes[4*(n-1-k) +: 4];
            e.ctl   = ctl;
            e.src   = {op == 2'b01, op == 2'b10, op};
            sb.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            check_cycle(e, instr);
            if (k < n - 1 || !hold) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        reset1       = 1'b0;
        bus.Instr    = 20'h00000;
        bus.ALUFlags = 4'h0;
        #1;
        chk("rst_async_state", {4'h0, bus.State}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {4'h0, bus.State}, 8'h00);
        chk("rst_we", obs_we(), 8'h00);
        chk("rst_ctl", obs_cv(), 8'b0_1_10_10_00);
        reset1 = 1'b1;

        issue(20'hE0821, 4'h0, 4, 20'h00168, 20'h0C002, 2'b00, 0); // ADD
        issue(20'hE5912, 4'h0, 5, 20'h01234, 20'hC0002, 2'b00, 0); // LDR
        issue(20'hE5812, 4'h0, 4, 20'h00125, 20'h0C001, 2'b00, 0); // STR
        issue(20'hE0521, 4'h4, 4, 20'h00168, 20'h0C002, 2'b01, 0); // SUBS Z=1
        issue(20'h0A000, 4'h0, 3, 20'h00019, 20'h00C08, 2'b00, 0); // BEQ taken
        issue(20'h1A000, 4'h0, 2, 20'h00001, 20'h000C0, 2'b00, 0); // BNE skipped
        issue(20'hE1921, 4'hB, 4, 20'h00168, 20'h0C002, 2'b11, 0); // ORRS -> 1000
        issue(20'h2A000, 4'h0, 2, 20'h00001, 20'h000C0, 2'b00, 0); // BCS skipped
        issue(20'h4A000, 4'h0, 3, 20'h00019, 20'h00C08, 2'b00, 0); // BMI taken
        issue(20'hBA000, 4'h0, 3, 20'h00019, 20'h00C08, 2'b00, 0); // BLT taken
        issue(20'hE0921, 4'h3, 4, 20'h00168, 20'h0C002, 2'b00, 0); // ADDS -> 0011
        issue(20'h2A000, 4'h0, 3, 20'h00019, 20'h00C08, 2'b00, 0); // BCS taken
        issue(20'h6A000, 4'h0, 3, 20'h00019, 20'h00C08, 2'b00, 0); // BVS taken
        issue(20'h8A000, 4'h0, 3, 20'h00019, 20'h00C08, 2'b00, 0); // BHI taken
        issue(20'h0A000, 4'h0, 2, 20'h00001, 20'h000C0, 2'b00, 0); // BEQ skipped
        issue(20'hE2811, 4'h0, 4, 20'h00178, 20'h0C002, 2'b00, 0); // ADD imm
        issue(20'hE0011, 4'h0, 4, 20'h00168, 20'h0C002, 2'b10, 0); // AND
        issue(20'hE0311, 4'h4, 4, 20'h00168, 20'h0C000, 2'b00, 0); // EORS unsupported
        issue(20'h0A000, 4'h0, 2, 20'h00001, 20'h000C0, 2'b00, 0); // flags kept 0011
        issue(20'hE082F, 4'h0, 4, 20'h00168, 20'h0C00A, 2'b00, 0); // ADD to PC
        issue(20'hE591F, 4'h0, 5, 20'h01234, 20'hC000A, 2'b00, 0); // LDR to PC
        issue(20'hEF000, 4'h0, 2, 20'h00001, 20'h000C0, 2'b00, 0); // Op=11
        issue(20'hF0821, 4'h0, 2, 20'h00001, 20'h000C0, 2'b00, 0); // cond NV
        issue(20'hE0521, 4'h4, 4, 20'h00168, 20'h0C002, 2'b01, 0); // SUBS Z=1
        issue(20'hE5812, 4'h0, 4, 20'h00125, 20'h0C001, 2'b00, 1); // STR, reset in MEMWR

        #1;
        reset1 = 1'b0;
        #1;
        chk("midrst_state", {4'h0, bus.State}, 8'h00);
        chk("midrst_we", obs_we(), 8'h00);
        @(posedge clk);
        #1;
        chk("midrst_hold_state", {4'h0, bus.State}, 8'h00);
        chk("midrst_hold_we", obs_we(), 8'h00);
        reset1 = 1'b1;
        issue(20'h0A000, 4'h0, 2, 20'h00001, 20'h000C0, 2'b00, 0); // flags cleared
        issue(20'hE0821, 4'h0, 4, 20'h00168, 20'h0C002, 2'b00, 0); // ADD resumes

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset1  in  1  asynchronous, active-low reset.
REQ-004 Instr  in  20  Instr[31:12] from the instruction register; stable outside FETCH.
REQ-005 ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
REQ-006 PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables.
REQ-007 AdrSrc  out  1  memory address select: 0=PC, 1=ALU result register.
REQ-008 RegSrc  out  2  register-read selects, same meaning as the single-cycle datapath.
REQ-009 ImmSrc  out  2  extend-unit select: 00 imm8, 01 imm12, 10 branch.
REQ-010 ALUSrcA  out  1  0=register A, 1=PC.
REQ-011 ALUSrcB  out  2  00=register WriteData, 01=ExtImm, 10=constant 4.
REQ-012 ResultSrc  out  2  00=ALUOut register, 01=Data register, 10=ALU result.
REQ-013 ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-014 State  out  4  current FSM state, for debug.

Function
REQ-015 FSM encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; codes 10-15 go to FETCH next cycle with no writes.
REQ-016 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1; next state DECODE.
REQ-017 DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10; no write enables.
REQ-018 DECODE transitions: CondEx=0 -> FETCH; Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH.
REQ-019 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00; next MEMRD if Funct[0]=1, else MEMWR.
REQ-020 MEMRD: AdrSrc=1, ResultSrc=00; next MEMWB.
REQ-021 MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-022 MEMWR: AdrSrc=1, MemWrite=1; next FETCH.
REQ-023 EXECUTER uses ALUSrcB=00; EXECUTEI uses ALUSrcB=01. Both: ALUSrcA=0, ALUControl from Funct[4:1] (0100 ADD, 0010 SUB, 0000 AND, 1100 ORR); next ALUWB.
REQ-024 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-025 BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ALUControl=00, ResultSrc=10, PCWrite=1; next FETCH.
REQ-026 ImmSrc = Op in every state; RegSrc[0] = (Op==10); RegSrc[1] = (Op==01).
REQ-027 CondEx: combinational from Instr[31:28] and the flags register, using the 15 ARM conditions; 1111 gives CondEx=0.
REQ-028 Flags register: 4 bits, reset 0000. In EXECUTER/EXECUTEI with S=Funct[0]=1 and CondEx=1, N,Z load from ALUFlags; C,V load only for ADD/SUB.
REQ-029 Unimplemented Funct[4:1]: ALUControl=00, RegWrite suppressed in ALUWB, flags unchanged.
REQ-030 Rd=1111 in MEMWB/ALUWB: PCWrite=1 in addition to RegWrite.
REQ-031 Latency: DP=4 cycles, LDR=5, STR=4, B=3, condition-failed=2 (FETCH, DECODE).

Reset
REQ-032 reset1=0 asynchronously forces State=FETCH and Flags=0000, independent of clk.
REQ-033 While reset1=0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0; other outputs follow FETCH decode.
REQ-034 Reset asserted mid-instruction abandons the instruction; no write enable is asserted after reset assertion.
REQ-035 First rising edge after reset1 rises: FETCH is executed with PCWrite=IRWrite=1.

Verification
REQ-036 ADD R1,R2,R3 (E0821003): State sequence 0,1,6,8,0; RegWrite=1 only in state 8; ALUControl=00 in state 6.
REQ-037 LDR (E5912004) then STR (E5812008): states 0,1,2,3,4 then 0,1,2,5; MemWrite=1 only in state 5; AdrSrc=1 in states 3 and 5.
REQ-038 SUBS (E0521003) with ALU returning Z=1, then BEQ (0A000002): flags become 0100; BEQ follows 0,1,9,0 with PCWrite=1 in state 9.
REQ-039 BNE (1A000002) with Z=1: states 0,1,0; no PCWrite in DECODE.
REQ-040 ORRS (E1921003) with ALUFlags=1011: N,Z load (flags[3:2]=10); C,V keep their prior values.
REQ-041 reset1 pulsed low during MEMWR: State=0 immediately; MemWrite=0; Flags=0000.
